// File: rtl/emu_sleep_ctrl.sv
// Purpose : paces an emulated model through a requested sleep duration by
//           issuing bounded per-cycle time steps and accumulating emulation time.
// Latency : accept -> done = ceil(req_dt/DT_MAX)+1 cycles without pause (1 cycle
//           for req_dt==0); each paused RUN cycle adds one cycle.
// Backpressure: req_ready is high only in IDLE; req_valid while not ready is
//           dropped, never queued.
//
// Ports
//   emu_clk     in   sole clock, all state on rising edge
//   emu_rst     in   synchronous active-high reset
//   req_valid   in   sleep request present
//   req_dt      in   requested duration in time LSBs, sampled on accept
//   req_ready   out  controller can accept a request (IDLE only)
//   pause       in   freezes time while in RUN, ignored elsewhere
//   model_rst   out  reset to the emulated model, held RST_CYCLES after emu_rst
//   emu_dt      out  time step applied this cycle, 0 = model frozen
//   emu_time    out  accumulated emulation time, wraps modulo 2^TIME_WIDTH
//   done        out  one-cycle pulse when a request has fully executed
//   reset_done  out  high once the model reset hold has completed

module emu_sleep_ctrl #(
    parameter int TIME_WIDTH = 40,
    parameter int DT_WIDTH   = 32,
    parameter int DT_MAX     = 100,
    parameter int RST_CYCLES = 4
) (
    input  logic                  emu_clk,
    input  logic                  emu_rst,
    input  logic                  req_valid,
    input  logic [DT_WIDTH-1:0]   req_dt,
    output logic                  req_ready,
    input  logic                  pause,
    output logic                  model_rst,
    output logic [DT_WIDTH-1:0]   emu_dt,
    output logic [TIME_WIDTH-1:0] emu_time,
    output logic                  done,
    output logic                  reset_done
);

    // Hold counter must be able to represent RST_CYCLES itself.
    localparam int                HOLD_W    = $clog2(RST_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [DT_WIDTH-1:0] STEP_MAX = DT_WIDTH'(DT_MAX);

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        IDLE     = 2'd1,
        RUN      = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [DT_WIDTH-1:0]    remaining_q, remaining_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [TIME_WIDTH-1:0]  time_q, time_d;
    logic                   done_q, done_d;
    logic                   model_rst_q, model_rst_d;
    logic                   reset_done_q, reset_done_d;

    logic [DT_WIDTH-1:0]    step;
    logic [DT_WIDTH-1:0]    rem_after;
    logic                   ready;

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        hold_d       = hold_q;
        time_d       = time_q;
        model_rst_d  = model_rst_q;
        reset_done_d = reset_done_q;
        step         = '0;
        rem_after    = remaining_q;
        ready        = 1'b0;

        case (state_q)
            RST_HOLD: begin
                // Counter was loaded with RST_CYCLES while emu_rst was high, so
                // leaving on the count of one gives exactly RST_CYCLES low cycles.
                if (hold_q <= HOLD_ONE) begin
                    state_d      = IDLE;
                    model_rst_d  = 1'b0;
                    reset_done_d = 1'b1;
                end else begin
                    hold_d = hold_q - HOLD_ONE;
                end
            end

            IDLE: begin
                ready = 1'b1;
                if (req_valid) begin
                    remaining_d = req_dt;
                    state_d     = (req_dt == '0) ? DONE : RUN;
                end
            end

            RUN: begin
                // Step is derived from registered remaining so the final step
                // is the residue and never overshoots the request.
                if (!pause) begin
                    step = (remaining_q < STEP_MAX) ? remaining_q : STEP_MAX;
                end
                rem_after   = remaining_q - step;
                remaining_d = rem_after;
                time_d      = time_q + TIME_WIDTH'(step);
                if (rem_after == '0) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = RST_HOLD;
            end
        endcase

        // done is registered: it is high for the single cycle spent in DONE.
        done_d = (state_d == DONE);
    end

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            state_q      <= RST_HOLD;
            remaining_q  <= '0;
            hold_q       <= HOLD_INIT;
            time_q       <= '0;
            done_q       <= 1'b0;
            model_rst_q  <= 1'b1;
            reset_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            hold_q       <= hold_d;
            time_q       <= time_d;
            done_q       <= done_d;
            model_rst_q  <= model_rst_d;
            reset_done_q <= reset_done_d;
        end
    end

    assign req_ready  = ready;
    assign emu_dt     = step;
    assign emu_time   = time_q;
    assign done       = done_q;
    assign model_rst  = model_rst_q;
    assign reset_done = reset_done_q;

endmodule

// File: tb/tb_emu_sleep_ctrl.sv
// Directed bench for emu_sleep_ctrl: a 40-bit-time instance and an 8-bit-time
// instance share stimulus; expected step/done events and status snapshots are
// queued by the stimulus and checked by an independent negedge monitor.

module tb_emu_sleep_ctrl;

    localparam int STEP = 100;

    logic        emu_clk;
    logic        emu_rst;
    logic        req_valid;
    logic [31:0] req_dt;
    logic        pause;

    logic        req_ready,  req_ready8;
    logic        model_rst,  model_rst8;
    logic [31:0] emu_dt,     emu_dt8;
    logic [39:0] emu_time;
    logic [7:0]  emu_time8;
    logic        done,       done8;
    logic        reset_done, reset_done8;

    emu_sleep_ctrl #(.TIME_WIDTH(40), .DT_WIDTH(32), .DT_MAX(STEP), .RST_CYCLES(4)) dut (
        .emu_clk(emu_clk), .emu_rst(emu_rst), .req_valid(req_valid), .req_dt(req_dt),
        .req_ready(req_ready), .pause(pause), .model_rst(model_rst), .emu_dt(emu_dt),
        .emu_time(emu_time), .done(done), .reset_done(reset_done)
    );

    emu_sleep_ctrl #(.TIME_WIDTH(8), .DT_WIDTH(32), .DT_MAX(STEP), .RST_CYCLES(4)) dut8 (
        .emu_clk(emu_clk), .emu_rst(emu_rst), .req_valid(req_valid), .req_dt(req_dt),
        .req_ready(req_ready8), .pause(pause), .model_rst(model_rst8), .emu_dt(emu_dt8),
        .emu_time(emu_time8), .done(done8), .reset_done(reset_done8)
    );

    typedef struct {
        int              cyc;
        bit              is_done;
        longint unsigned val;    // step size, or emu_time at done
        longint unsigned val8;   // emu_time of the 8-bit instance at done
    } ev_t;

    typedef struct {
        int              cyc;
        bit              mrst;
        bit              rdy;
        bit              rdone;
        longint unsigned dt;
        longint unsigned t;
        longint unsigned t8;
    } st_t;

    ev_t evq[$];
    st_t sq[$];

    int              cyc = 0;
    int              nvec = 0;
    int              nfail = 0;
    longint unsigned t_model = 0;

    initial begin
        emu_clk = 1'b0;
        forever #5 emu_clk = ~emu_clk;
    end

    always @(posedge emu_clk) cyc <= cyc + 1;

    // Monitor: compares whatever the DUTs present against the queued expectations.
    always @(negedge emu_clk) begin : mon
        ev_t e;
        st_t s;
        bit  ok;
        while (evq.size() > 0 && evq[0].cyc < cyc) begin
            e = evq.pop_front();
            nvec++;
            nfail++;
            $display("FAIL missing_event cyc=%0d expected done=%0b val=%0d at cyc=%0d",
                     cyc, e.is_done, e.val, e.cyc);
        end
        if (!emu_rst && (emu_dt != 0 || done || emu_dt8 != 0 || done8)) begin
            if (evq.size() == 0 || evq[0].cyc != cyc) begin
                nvec++;
                nfail++;
                $display("FAIL unexpected_event cyc=%0d got emu_dt=%0d done=%0b emu_dt8=%0d done8=%0b",
                         cyc, emu_dt, done, emu_dt8, done8);
            end else begin
                e = evq.pop_front();
                nvec++;
                if (e.is_done)
                    ok = done && done8 && emu_dt == 0 && emu_dt8 == 0 &&
                         longint'(emu_time) == e.val && longint'(emu_time8) == e.val8;
                else
                    ok = !done && !done8 && longint'(emu_dt) == e.val && longint'(emu_dt8) == e.val;
                if (!ok)
                    $display("FAIL %s cyc=%0d got dt=%0d/%0d done=%0b/%0b time=%0d/%0d exp val=%0d time8=%0d",
                             e.is_done ? "done_event" : "step_event", cyc, emu_dt, emu_dt8,
                             done, done8, emu_time, emu_time8, e.val, e.val8);
                if (!ok) nfail++;
            end
        end
        while (sq.size() > 0 && sq[0].cyc <= cyc) begin
            s = sq.pop_front();
            nvec++;
            ok = (s.cyc == cyc) && model_rst == s.mrst && model_rst8 == s.mrst &&
                 req_ready == s.rdy && req_ready8 == s.rdy &&
                 reset_done == s.rdone && reset_done8 == s.rdone &&
                 longint'(emu_dt) == s.dt && longint'(emu_time) == s.t &&
                 longint'(emu_time8) == s.t8;
            if (!ok) begin
                nfail++;
                $display("FAIL status cyc=%0d got mrst=%0b rdy=%0b rdone=%0b dt=%0d time=%0d time8=%0d exp cyc=%0d mrst=%0b rdy=%0b rdone=%0b dt=%0d time=%0d time8=%0d",
                         cyc, model_rst, req_ready, reset_done, emu_dt, emu_time, emu_time8,
                         s.cyc, s.mrst, s.rdy, s.rdone, s.dt, s.t, s.t8);
            end
        end
    end

    function automatic st_t mk_st(int c, bit mrst, bit rdy, bit rdone, longint unsigned dt,
                                  longint unsigned t);
        st_t s;
        s.cyc = c; s.mrst = mrst; s.rdy = rdy; s.rdone = rdone;
        s.dt = dt; s.t = t; s.t8 = t % 256;
        return s;
    endfunction

    function automatic ev_t mk_ev(int c, bit is_done, longint unsigned val, longint unsigned t);
        ev_t e;
        e.cyc = c; e.is_done = is_done; e.val = val; e.val8 = t % 256;
        return e;
    endfunction

    // Asserts emu_rst now for n rising edges, releases it, then expects
    // model_rst held for 4 cycles followed by IDLE with reset_done set.
    task automatic do_reset(input int n);
        int r;
        emu_rst = 1'b1;
        req_valid = 1'b0;
        pause = 1'b0;
        repeat (n) @(posedge emu_clk);
        #1;
        emu_rst = 1'b0;
        r = cyc;
        t_model = 0;
        for (int i = 0; i < 4; i++) sq.push_back(mk_st(r + i, 1'b1, 1'b0, 1'b0, 0, 0));
        sq.push_back(mk_st(r + 4, 1'b0, 1'b1, 1'b1, 0, 0));
        repeat (5) @(posedge emu_clk);
        #1;
    endtask

    // Issues one request; pidx = RUN-cycle index to pause (-1 none); hp holds
    // pause high for the whole request. A second, ignored request is offered
    // in the cycle after accept.
    task automatic do_req(input int unsigned dt, input int pidx, input bit hp);
        int              a;
        int              c;
        int              ri;
        longint unsigned rem;
        longint unsigned stp;
        longint unsigned first;
        @(posedge emu_clk);
        #1;
        req_valid = 1'b1;
        req_dt    = dt;
        pause     = hp;
        a = cyc + 1;
        first = (dt < STEP) ? dt : STEP;
        if (pidx == 0 || hp) first = 0;
        sq.push_back(mk_st(a, 1'b0, 1'b0, 1'b1, first, t_model));
        rem = dt;
        c   = a;
        ri  = 0;
        while (rem != 0) begin
            if (ri != pidx) begin
                stp = (rem < STEP) ? rem : STEP;
                evq.push_back(mk_ev(c, 1'b0, stp, 0));
                rem     = rem - stp;
                t_model = t_model + stp;
            end
            c++;
            ri++;
        end
        evq.push_back(mk_ev(c, 1'b1, t_model, t_model));
        @(posedge emu_clk);
        #1;
        req_dt = 32'd7;
        for (int k = 0; k < 300 && evq.size() != 0; k++) begin
            @(posedge emu_clk);
            #1;
            req_valid = 1'b0;
            pause = hp || (pidx >= 0 && cyc == a + pidx);
        end
        pause     = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        int a;
        emu_rst   = 1'b1;
        req_valid = 1'b0;
        req_dt    = '0;
        pause     = 1'b0;

        do_reset(2);
        do_req(250, -1, 1'b0);     // 100,100,50 then done, time 250
        do_req(0, -1, 1'b1);       // immediate done, pause outside RUN has no effect
        do_req(250, 1, 1'b0);      // 100,0,100,50 then done, time 500
        do_req(100, -1, 1'b0);     // exact multiple: single full step
        do_req(1, -1, 1'b0);       // smallest non-zero request

        // Abort: reset while the second step is being presented.
        @(posedge emu_clk);
        #1;
        req_valid = 1'b1;
        req_dt    = 32'd250;
        a = cyc + 1;
        evq.push_back(mk_ev(a, 1'b0, STEP, 0));
        @(posedge emu_clk);
        #1;
        req_valid = 1'b0;
        @(posedge emu_clk);
        #1;
        do_reset(2);
        do_req(30, -1, 1'b0);      // time restarts from zero: 30

        // Wrap check on the 8-bit instance: 200 then 400 mod 256 = 144.
        do_reset(1);
        do_req(200, -1, 1'b0);
        do_req(200, -1, 1'b0);

        for (int k = 0; k < 20 && (evq.size() != 0 || sq.size() != 0); k++)
            @(posedge emu_clk);
        repeat (2) @(posedge emu_clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
